muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_negate.sv | 22 ++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared op codes, FSM states and sizing helpers for the
//                HI/LO multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Operation codes presented on op together with start
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Iteration counter width for a given operand width
  function automatic int md_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MD_DEFAULT_WIDTH = 32;
  localparam int MD_CNT_W         = md_cnt_width(MD_DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_negate
//  Description : Combinational conditional two's-complement. Used for operand
//                magnitudes and for sign fix-up of results.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // Pass through, or negate when requested
  always_comb begin
    o_val = i_neg ? (WIDTH'(0) - i_val) : i_val;
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative HI/LO multiply/divide unit. Shift-add multiply and
//                restoring divide, one bit per clock, on operand magnitudes,
//                followed by a single sign fix-up / write-back cycle.
//                MTHI/MTLO complete in the cycle they are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                c_CNT_W     = md_cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(WIDTH - 1);

  md_state_t            r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     r_a_raw;   // raw dividend for the divide-by-zero result
  logic                 r_is_div;
  logic                 r_neg_q;   // negate product / quotient
  logic                 r_neg_r;   // negate remainder
  logic                 r_div0;

  logic                 w_signed_op;
  logic                 w_div_op;
  logic                 w_md_op;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_sub;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_prod;

  // Decode the requested operation class
  always_comb begin
    w_signed_op = (op == MD_MULT) || (op == MD_DIV);
    w_div_op    = (op == MD_DIV)  || (op == MD_DIVU);
    w_md_op     = (op == MD_MULT) || (op == MD_MULTU) || w_div_op;
  end

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
    .i_neg (w_signed_op & a[WIDTH-1]),
    .i_val (a),
    .o_val (w_abs_a)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
    .i_neg (w_signed_op & b[WIDTH-1]),
    .i_val (b),
    .o_val (w_abs_b)
  );

  // One multiply step and one restoring-divide step from the current state
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{r_acc[0]}} & r_opnd)};
    w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], w_div_ge};
  end

  // Sign fix-up of quotient, remainder and full product
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_q (
    .i_neg (r_neg_q),
    .i_val (r_acc[WIDTH-1:0]),
    .o_val (w_quot)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_fix_r (
    .i_neg (r_neg_r),
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .o_val (w_rem)
  );

  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_p (
    .i_neg (r_neg_q),
    .i_val (r_acc),
    .o_val (w_prod)
  );

  // Sequencer: accept requests in IDLE, iterate in CALC, write back in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_md_op) begin
              r_state  <= ST_CALC;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= w_div_op;
              r_neg_q  <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= w_signed_op & a[WIDTH-1];
              r_div0   <= (b == '0);
              r_a_raw  <= a;
              r_acc    <= {{WIDTH{1'b0}}, (w_div_op ? w_abs_a : w_abs_b)};
              r_opnd   <= w_div_op ? w_abs_b : w_abs_a;
            end else if (op == MD_MTHI) begin
              r_hi <= a;
            end else if (op == MD_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == c_LAST_ITER) begin
            r_state <= ST_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
